wishbone_bus_arbiter: RTL

N-to-1 Wishbone Classic arbiter: connects several Wishbone masters to a single shared slave port, typically the master port of the existing 1-to-N splitter. Round-robin grant, held for the full CYC of the granted master, with a response watchdog that terminates hung strobes with ERR. Registered grant, combinational data/handshake routing once granted.

---
 rtl/wb_bus_pkg.sv | 25 ++
 rtl/wb_rr_arbiter.sv | 41 ++++
 rtl/wishbone_bus_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/wb_bus_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_bus_pkg
// Brief   : Shared Wishbone bus types and constants for the arbiter and splitter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_bus_pkg;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

    localparam int c_wb_addr_width = 32;
    localparam int c_wb_data_width = 32;

    // A zero timeout still needs a legal 1-bit counter declaration.
    function automatic int wdog_width(input int cycles);
        return (cycles <= 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module  : wb_rr_arbiter
// Brief   : Combinational round-robin picker; searches upward from last_grant+1.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   valid
);

    int               w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        valid      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            w_cand     = (int'(last_grant) + off) % NUM_MASTERS;
            w_cand_idx = IDX_W'(w_cand);
            if (!valid && req[w_cand_idx]) begin
                valid             = 1'b1;
                grant_idx         = w_cand_idx;
                grant[w_cand_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/wishbone_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module  : wishbone_bus_arbiter
// Brief   : N-to-1 Wishbone Classic arbiter, round-robin, CYC-held grant, watchdog.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wishbone_bus_arbiter
    import wb_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
    input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
    output logic [DATA_WIDTH-1:0]             m_wb_dat_o,
    output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
    output logic [NUM_MASTERS-1:0]            m_wb_err_o,
    output logic                              s_wb_cyc_o,
    output logic                              s_wb_stb_o,
    output logic                              s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
    output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
    input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
    input  logic                              s_wb_ack_i,
    input  logic                              s_wb_err_i,
    output logic [NUM_MASTERS-1:0]            grant_o
);

    localparam int c_idx_w = $clog2(NUM_MASTERS);
    localparam int c_cnt_w = wdog_width(TIMEOUT_CYCLES);

    arb_state_e               r_state;
    logic [NUM_MASTERS-1:0]   r_grant;
    logic [c_idx_w-1:0]       r_grant_idx;
    logic [c_idx_w-1:0]       r_last_grant;
    logic                     r_to_err;

    logic [NUM_MASTERS-1:0]   w_arb_grant;
    logic [c_idx_w-1:0]       w_arb_idx;
    logic                     w_arb_valid;
    logic                     w_release;

    logic [ADDR_WIDTH-1:0]    w_adr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]    w_dat [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]     w_sel [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
        assign w_adr[i] = m_wb_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_dat[i] = m_wb_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_sel[i] = m_wb_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
    end

    wb_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_idx_w)
    ) u_rr_arbiter (
        .req        (m_wb_cyc_i),
        .last_grant (r_last_grant),
        .grant      (w_arb_grant),
        .grant_idx  (w_arb_idx),
        .valid      (w_arb_valid)
    );

    assign w_release = (r_state == GRANTED) && !m_wb_cyc_i[r_grant_idx];

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            r_last_grant <= c_idx_w'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_state     <= GRANTED;
                        r_grant     <= w_arb_grant;
                        r_grant_idx <= w_arb_idx;
                    end
                end
                GRANTED: begin
                    // Grant is only surrendered when the owner ends its cycle.
                    if (w_release) begin
                        r_state      <= IDLE;
                        r_grant      <= '0;
                        r_last_grant <= r_grant_idx;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    if (TIMEOUT_CYCLES > 0) begin : g_wdog
        logic [c_cnt_w-1:0] r_wdog_cnt;

        always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
            if (!wb_rst_ni) begin
                r_wdog_cnt <= '0;
                r_to_err   <= 1'b0;
            end else if (r_state != GRANTED || w_release || !s_wb_stb_o ||
                         s_wb_ack_i || s_wb_err_i) begin
                r_wdog_cnt <= '0;
                r_to_err   <= 1'b0;
            end else if (r_wdog_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) begin
                r_wdog_cnt <= '0;
                r_to_err   <= 1'b1;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
                r_to_err   <= 1'b0;
            end
        end
    end else begin : g_no_wdog
        assign r_to_err = 1'b0;
    end

    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        s_wb_sel_o = '0;
        m_wb_ack_o = '0;
        m_wb_err_o = '0;
        m_wb_dat_o = '0;
        if (r_state == GRANTED) begin
            s_wb_cyc_o = m_wb_cyc_i[r_grant_idx];
            s_wb_stb_o = m_wb_stb_i[r_grant_idx] & ~r_to_err;
            s_wb_we_o  = m_wb_we_i[r_grant_idx];
            s_wb_adr_o = w_adr[r_grant_idx];
            s_wb_dat_o = w_dat[r_grant_idx];
            s_wb_sel_o = w_sel[r_grant_idx];
            // A late slave response in the timeout cycle is swallowed.
            m_wb_ack_o[r_grant_idx] = s_wb_ack_i & ~r_to_err;
            m_wb_err_o[r_grant_idx] = (s_wb_err_i & ~r_to_err) | r_to_err;
            m_wb_dat_o = s_wb_dat_i;
        end
    end

    assign grant_o = r_grant;

endmodule

`default_nettype wire
